// File: rtl/upload_frame_mux_pkg.sv
// Shared constants and types for the multi-channel framed upload path.
package upload_frame_mux_pkg;

    localparam logic [7:0] SOF0_BYTE = 8'hAA;
    localparam logic [7:0] SOF1_BYTE = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF0 = 3'd1,
        ST_SOF1 = 3'd2,
        ST_CHN  = 3'd3,
        ST_LEN  = 3'd4,
        ST_DATA = 3'd5,
        ST_CHK  = 3'd6
    } state_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/upload_frame_mux_if.sv
// Byte-stream bundle: NUM_CH input channels plus the single framed upload stream.
interface upload_frame_mux_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   in_valid;
    logic [NUM_CH*8-1:0] in_data;
    logic [NUM_CH-1:0]   in_ready;
    logic [7:0]          up_data;
    logic                up_valid;
    logic                up_ready;

    modport master (
        output in_valid, in_data, up_ready,
        input  in_ready, up_data, up_valid
    );

    modport slave (
        input  in_valid, in_data, up_ready,
        output in_ready, up_data, up_valid
    );
endinterface

// File: rtl/upload_frame_mux_chan_fifo.sv
// Per-channel synchronous first-word-fall-through byte FIFO with occupancy count.
module upload_frame_mux_chan_fifo #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [7:0]       wr_data,
    input  logic             rd,
    output logic [7:0]       rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr && !full;
    assign do_rd   = rd && !empty;
    // Storage is flops, so the head byte is presented without a read cycle.
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/upload_frame_mux.sv
// Round-robin multiplexer of NUM_CH buffered byte channels into framed upload packets.
//  state | meaning
//  IDLE  | no frame in flight; grant first eligible channel from rr_ptr
//  SOF0  | emit 8'hAA
//  SOF1  | emit 8'h55
//  CHN   | emit granted channel number
//  LEN   | emit latched payload length
//  DATA  | emit payload bytes straight from the granted FIFO head
//  CHK   | emit XOR of CH, LEN and payload
module upload_frame_mux
    import upload_frame_mux_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int FIFO_DEPTH  = 64,
    parameter int MAX_PKT     = 32,
    parameter int TIMEOUT_CYC = 6000
) (
    input  logic                 clk,
    input  logic                 rst,
    upload_frame_mux_if.slave    bus,
    output logic [NUM_CH-1:0]    ch_overflow,
    output logic                 busy
);
    localparam int CNT_W = cnt_w(FIFO_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] rd_en;
    logic [NUM_CH-1:0] eligible;
    logic [7:0]        rd_data [NUM_CH];
    logic [CNT_W-1:0]  count   [NUM_CH];
    logic [TMO_W-1:0]  tmo     [NUM_CH];

    state_t            state;
    state_t            state_nx;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   cand;
    logic              grant_vld;
    logic              grant_fire;
    logic [CNT_W-1:0]  grant_cnt;
    logic [7:0]        grant_len;
    logic [7:0]        len;
    logic [7:0]        pay_left;
    logic [7:0]        chk;
    logic [7:0]        up_data;
    logic              up_valid;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_en[i]    = bus.in_valid[i] && !full[i];
        assign rd_en[i]    = (state == ST_DATA) && bus.up_ready && (cur_ch == CH_W'(i));
        assign eligible[i] = (count[i] >= CNT_W'(MAX_PKT)) ||
                             (!empty[i] && (tmo[i] == TMO_W'(TIMEOUT_CYC)));

        upload_frame_mux_chan_fifo #(
            .DEPTH (FIFO_DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr      (bus.in_valid[i]),
            .wr_data (bus.in_data[8*i +: 8]),
            .rd      (rd_en[i]),
            .rd_data (rd_data[i]),
            .full    (full[i]),
            .empty   (empty[i]),
            .count   (count[i])
        );
    end

    assign bus.in_ready = ~full;
    assign bus.up_data  = up_data;
    assign bus.up_valid = up_valid;
    assign busy         = (state != ST_IDLE);

    // Walk downward so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (eligible[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
    end

    assign grant_fire = (state == ST_IDLE) && grant_vld;
    assign grant_cnt  = count[grant_ch];
    assign grant_len  = (grant_cnt >= CNT_W'(MAX_PKT)) ? 8'(MAX_PKT) : 8'(grant_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) tmo[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en[i] || (grant_fire && (grant_ch == CH_W'(i))))
                    tmo[i] <= '0;
                else if (!empty[i] && (tmo[i] != TMO_W'(TIMEOUT_CYC)))
                    tmo[i] <= tmo[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ch_overflow <= '0;
        else     ch_overflow <= ch_overflow | (bus.in_valid & full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        up_valid = 1'b1;
        up_data  = 8'h00;
        case (state)
            ST_IDLE: begin
                up_valid = 1'b0;
                if (grant_vld) state_nx = ST_SOF0;
            end
            ST_SOF0: begin
                up_data = SOF0_BYTE;
                if (bus.up_ready) state_nx = ST_SOF1;
            end
            ST_SOF1: begin
                up_data = SOF1_BYTE;
                if (bus.up_ready) state_nx = ST_CHN;
            end
            ST_CHN: begin
                up_data = 8'(cur_ch);
                if (bus.up_ready) state_nx = ST_LEN;
            end
            ST_LEN: begin
                up_data = len;
                if (bus.up_ready) state_nx = ST_DATA;
            end
            ST_DATA: begin
                up_data = rd_data[cur_ch];
                if (bus.up_ready && (pay_left == 8'd1)) state_nx = ST_CHK;
            end
            ST_CHK: begin
                up_data = chk;
                if (bus.up_ready) state_nx = ST_IDLE;
            end
            default: begin
                up_valid = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            cur_ch   <= '0;
            len      <= '0;
            pay_left <= '0;
            chk      <= '0;
        end else if (grant_fire) begin
            cur_ch   <= grant_ch;
            len      <= grant_len;
            pay_left <= grant_len;
            chk      <= 8'(grant_ch) ^ grant_len;
            rr_ptr   <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
        end else if ((state == ST_DATA) && bus.up_ready) begin
            pay_left <= pay_left - 1'b1;
            chk      <= chk ^ rd_data[cur_ch];
        end
    end

endmodule

// File: tb/tb_upload_frame_mux.sv
// Self-checking bench: queue-based frame model plus directed and randomized traffic.
module tb_upload_frame_mux;
    localparam int NCH   = 4;
    localparam int DEPTH = 64;
    localparam int MAXP  = 32;
    localparam int TMO   = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   ch_overflow;
    logic             busy;

    upload_frame_mux_if #(.NUM_CH(NCH)) bus();

    upload_frame_mux #(
        .NUM_CH      (NCH),
        .FIFO_DEPTH  (DEPTH),
        .MAX_PKT     (MAXP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ch_overflow (ch_overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: per-channel byte queues, last-clear timestamps, expected frame.
    logic [7:0] mq [NCH][$];
    int         clear_cyc [NCH];
    logic [NCH-1:0] ovf_m;
    int         rr_m;
    bit         m_busy;
    int         m_ch;
    int         fidx;
    logic [7:0] frame [$];
    int         cyc;
    logic [7:0] got [$];

    task automatic start_frame(input int c, input int n);
        int len;
        logic [7:0] x;
        len = (n < MAXP) ? n : MAXP;
        frame.delete();
        frame.push_back(8'hAA);
        frame.push_back(8'h55);
        frame.push_back(8'(c));
        frame.push_back(8'(len));
        x = 8'(c) ^ 8'(len);
        for (int i = 0; i < len; i++) begin
            frame.push_back(mq[c][i]);
            x = x ^ mq[c][i];
        end
        frame.push_back(x);
        m_ch         = c;
        fidx         = 0;
        m_busy       = 1'b1;
        rr_m         = (c + 1) % NCH;
        clear_cyc[c] = cyc + 1;
    endtask

    always @(negedge clk) begin
        int sz [NCH];
        int c;
        if (rst) begin
            chk_eq("rst_up_valid", bus.up_valid, 0);
            chk_eq("rst_up_data", bus.up_data, 0);
            chk_eq("rst_busy", busy, 0);
            chk_eq("rst_in_ready", bus.in_ready, {NCH{1'b1}});
            chk_eq("rst_overflow", ch_overflow, 0);
            for (int i = 0; i < NCH; i++) begin
                mq[i].delete();
                clear_cyc[i] = 0;
            end
            ovf_m  = '0;
            rr_m   = 0;
            m_busy = 1'b0;
            frame.delete();
        end else begin
            cyc++;
            for (int i = 0; i < NCH; i++) sz[i] = mq[i].size();
            for (int i = 0; i < NCH; i++) chk_eq("in_ready", bus.in_ready[i], sz[i] < DEPTH);
            chk_eq("ch_overflow", ch_overflow, ovf_m);
            chk_eq("busy", busy, m_busy);
            chk_eq("up_valid", bus.up_valid, m_busy);
            if (m_busy) begin
                chk_eq("up_data", bus.up_data, frame[fidx]);
                if (bus.up_ready) begin
                    got.push_back(bus.up_data);
                    if (fidx >= 4 && fidx < frame.size() - 1) void'(mq[m_ch].pop_front());
                    fidx++;
                    if (fidx == frame.size()) m_busy = 1'b0;
                end
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    c = (rr_m + k) % NCH;
                    if (!m_busy && (sz[c] >= MAXP || (sz[c] > 0 && cyc - clear_cyc[c] >= TMO)))
                        start_frame(c, sz[c]);
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (bus.in_valid[i]) begin
                    if (sz[i] < DEPTH) begin
                        mq[i].push_back(bus.in_data[8*i +: 8]);
                        clear_cyc[i] = cyc + 1;
                    end else begin
                        ovf_m[i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = '0;
        bus.in_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        got.delete();
    endtask

    task automatic wait_got(input int n, input int budget, input string tag);
        int t = 0;
        while (got.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        chk_eq(tag, got.size(), n);
    endtask

    task automatic burst(input logic [NCH-1:0] mask, input int n, input bit counting);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = mask;
            for (int ch = 0; ch < NCH; ch++)
                bus.in_data[8*ch +: 8] = counting ? 8'(i) : 8'($urandom);
            tick(1);
        end
        idle_inputs();
    endtask

    logic [7:0] exp1 [8];
    logic [7:0] t4_data [32];
    logic [7:0] x4;
    int         n6;

    initial begin
        idle_inputs();
        bus.up_ready = 1'b0;
        tick(3);
        rst = 1'b0;

        // Single short write, flushed by timeout.
        do_reset();
        bus.up_ready = 1'b1;
        bus.in_valid = 4'b0100;
        bus.in_data[23:16] = 8'h11; tick(1);
        bus.in_data[23:16] = 8'h22; tick(1);
        bus.in_data[23:16] = 8'h33; tick(1);
        idle_inputs();
        exp1 = '{8'hAA, 8'h55, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33,
                 8'h02 ^ 8'h03 ^ 8'h11 ^ 8'h22 ^ 8'h33};
        wait_got(8, TMO + 40, "t1_bytes");
        for (int i = 0; i < 8; i++) chk_eq("t1_frame", got[i], exp1[i]);

        // 40-byte burst: full frame then timed-out remainder.
        do_reset();
        bus.up_ready = 1'b1;
        burst(4'b0001, 40, 1'b1);
        wait_got(50, TMO + 150, "t2_bytes");
        chk_eq("t2_len1", got[3], 8'h20);
        chk_eq("t2_first", got[4], 8'd0);
        chk_eq("t2_last1", got[35], 8'd31);
        chk_eq("t2_len2", got[40], 8'h08);
        chk_eq("t2_first2", got[41], 8'd32);
        chk_eq("t2_last2", got[48], 8'd39);

        // Three channels full in the same cycle, then refill of ch0/ch1.
        do_reset();
        bus.up_ready = 1'b1;
        burst(4'b1011, 32, 1'b0);
        wait_got(111, 200, "t3_bytes");
        chk_eq("t3_ch_a", got[2], 0);
        chk_eq("t3_ch_b", got[39], 1);
        chk_eq("t3_ch_c", got[76], 3);
        got.delete();
        burst(4'b0011, 32, 1'b0);
        wait_got(74, 150, "t3_refill_bytes");
        chk_eq("t3_refill_a", got[2], 0);
        chk_eq("t3_refill_b", got[39], 1);

        // Throttled downstream: one cycle ready, two stalled.
        do_reset();
        bus.up_ready = 1'b0;
        for (int i = 0; i < 32; i++) t4_data[i] = 8'($urandom);
        for (int i = 0; i < 32; i++) begin
            bus.in_valid = 4'b0010;
            bus.in_data[15:8] = t4_data[i];
            tick(1);
        end
        idle_inputs();
        for (int t = 0; t < 300 && got.size() < 37; t++) begin
            bus.up_ready = (t % 3 == 0);
            tick(1);
        end
        bus.up_ready = 1'b1;
        chk_eq("t4_bytes", got.size(), 37);
        x4 = 8'h01 ^ 8'h20;
        for (int i = 0; i < 32; i++) begin
            chk_eq("t4_payload", got[4 + i], t4_data[i]);
            x4 = x4 ^ t4_data[i];
        end
        chk_eq("t4_chk", got[36], x4);

        // Overflow: 65 bytes into a 64-deep FIFO with the output blocked.
        do_reset();
        bus.up_ready = 1'b0;
        burst(4'b0010, 65, 1'b1);
        chk_eq("t5_in_ready", bus.in_ready[1], 0);
        chk_eq("t5_overflow", ch_overflow[1], 1);
        bus.up_ready = 1'b1;
        wait_got(74, 200, "t5_bytes");
        tick(TMO + 20);
        chk_eq("t5_total", got.size(), 74);
        chk_eq("t5_last", got[72], 8'd63);

        // Reset in the middle of a payload.
        do_reset();
        bus.up_ready = 1'b1;
        burst(4'b0001, 32, 1'b0);
        wait_got(6, 80, "t6_bytes");
        rst = 1'b1;
        #2;
        chk_eq("t6_up_valid", bus.up_valid, 0);
        chk_eq("t6_busy", busy, 0);
        chk_eq("t6_in_ready", bus.in_ready, 4'hF);
        tick(1);
        rst = 1'b0;
        n6 = got.size();
        tick(2 * TMO);
        chk_eq("t6_no_frame", got.size(), n6);

        // Randomized traffic at two input rates, random backpressure.
        do_reset();
        for (int phase = 0; phase < 2; phase++) begin
            for (int t = 0; t < 2500; t++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    bus.in_valid[ch] = ($urandom_range(0, 99) < (phase == 0 ? 8 : 35));
                    bus.in_data[8*ch +: 8] = 8'($urandom);
                end
                bus.up_ready = ($urandom_range(0, 99) < 75);
                tick(1);
            end
        end
        idle_inputs();
        bus.up_ready = 1'b1;
        tick(1000);
        chk_eq("drain_busy", busy, 0);
        chk_eq("drain_up_valid", bus.up_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
